// File: rtl/score_display.sv
// Three-digit multiplexed 7-segment driver for a BCD score.
//
// Scans units, tens and hundreds in turn, SCAN_DIV clocks per digit. The
// first GUARD clocks of every slot are blanked so the previous digit's
// segments never ghost onto the next enable. The displayed value is a
// snapshot taken only at frame end, so the digits never tear mid-frame.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   num1       - units digit (BCD)
//   num2       - tens digit (BCD)
//   num3       - hundreds digit (BCD)
//   upd        - request to capture num1..num3 at the next frame end
//   seg        - segments {a,b,c,d,e,f,g}, active-high, registered
//   dig_en     - one-hot digit enable {hundreds,tens,units}, registered
//   frame_done - one-cycle pulse after each frame end
//   err        - sticky: a captured digit was not BCD
module score_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic       upd,
    output logic [6:0] seg,
    output logic [2:0] dig_en,
    output logic       frame_done,
    output logic       err
);

    localparam logic [15:0] LastCnt  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GuardCnt = 16'(GUARD);

    typedef enum logic [1:0] {S_UNITS, S_TENS, S_HUNDREDS} state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  u_q, t_q, h_q;
    logic        pending_q;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  dig_en_q, dig_en_d;
    logic        frame_done_q;
    logic        err_q;

    logic slot_end;
    logic frame_end;
    logic load;
    logic tens_blank;
    logic hund_blank;

    // Non-BCD codes show a lone middle dash.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h01;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == LastCnt);
    assign frame_end = slot_end && (state_q == S_HUNDREDS);
    // An upd arriving on the frame-end cycle itself is honoured immediately.
    assign load      = frame_end && (pending_q || upd);

    // Leading-zero blanking; a non-BCD digit is nonzero and so stays lit.
    assign hund_blank = (h_q == 4'd0);
    assign tens_blank = (h_q == 4'd0) && (t_q == 4'd0);

    always_comb begin
        seg_d    = 7'h00;
        dig_en_d = 3'b000;
        if (cnt_q >= GuardCnt) begin
            unique case (state_q)
                S_UNITS: begin
                    dig_en_d = 3'b001;
                    seg_d    = seg_code(u_q);
                end
                S_TENS: begin
                    if (!tens_blank) begin
                        dig_en_d = 3'b010;
                        seg_d    = seg_code(t_q);
                    end
                end
                S_HUNDREDS: begin
                    if (!hund_blank) begin
                        dig_en_d = 3'b100;
                        seg_d    = seg_code(h_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_UNITS;
            cnt_q        <= 16'd0;
            u_q          <= 4'd0;
            t_q          <= 4'd0;
            h_q          <= 4'd0;
            pending_q    <= 1'b0;
            seg_q        <= 7'h00;
            dig_en_q     <= 3'b000;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q <= slot_end ? 16'd0 : cnt_q + 16'd1;

            if (slot_end) begin
                unique case (state_q)
                    S_UNITS:    state_q <= S_TENS;
                    S_TENS:     state_q <= S_HUNDREDS;
                    S_HUNDREDS: state_q <= S_UNITS;
                    default:    state_q <= S_UNITS;
                endcase
            end

            frame_done_q <= frame_end;

            if (load) begin
                u_q       <= num1;
                t_q       <= num2;
                h_q       <= num3;
                pending_q <= 1'b0;
                if ((num1 > 4'd9) || (num2 > 4'd9) || (num3 > 4'd9)) begin
                    err_q <= 1'b1;
                end
            end else if (upd) begin
                pending_q <= 1'b1;
            end

            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 4..65535.
REQ-002 The block SHALL have parameter GUARD, default 2: blanked cycles at the start of each slot, legal range 1..SCAN_DIV-2.
REQ-003 Port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port num1, input, 4 bits: units digit, 8421 BCD.
REQ-006 Port num2, input, 4 bits: tens digit, 8421 BCD.
REQ-007 Port num3, input, 4 bits: hundreds digit, 8421 BCD.
REQ-008 Port upd, input, 1 bit: strobe requesting capture of num1..num3.
REQ-009 Port seg, output, 7 bits: segments {a,b,c,d,e,f,g}, MSB = a, active-high.
REQ-010 Port dig_en, output, 3 bits: one-hot digit enable, active-high; bit0 = units, bit1 = tens, bit2 = hundreds.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse at the end of each scan frame.
REQ-012 Port err, output, 1 bit: sticky flag set when a captured digit is not BCD.

Function
REQ-013 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-014 Scan FSM states SHALL be S_UNITS, S_TENS, S_HUNDREDS.
REQ-015 The FSM SHALL advance only in the cycle where cnt == SCAN_DIV-1: S_UNITS->S_TENS->S_HUNDREDS->S_UNITS.
REQ-016 frame_done SHALL be 1 for exactly the cycle following the S_HUNDREDS->S_UNITS transition edge, and 0 otherwise.
REQ-017 The block SHALL display from an internal snapshot {h,t,u}, never from num1..num3 directly.
REQ-018 upd == 1 in any cycle SHALL set the pending flag.
REQ-019 On the S_HUNDREDS->S_UNITS edge, if pending or upd is 1, the snapshot SHALL load {num3,num2,num1} and pending SHALL clear.
REQ-020 Multiple upd pulses within one frame SHALL produce one load, taking the values present on the load edge.
REQ-021 seg and dig_en SHALL be registered, reflecting state and cnt with one cycle of latency.
REQ-022 dig_en SHALL be 000 and seg SHALL be 0000000 while the previous-cycle cnt < GUARD (anti-ghost guard).
REQ-023 Outside the guard, dig_en SHALL be one-hot for the current state, unless that digit is blanked.
REQ-024 Segment codes SHALL be: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex).
REQ-025 Digit values 10..15 SHALL display 01 (dash only) and SHALL set err on the load edge.
REQ-026 Leading-zero blanking: the hundreds digit is blanked if h == 0.
REQ-027 Leading-zero blanking: the tens digit is blanked if h == 0 and t == 0.
REQ-028 The units digit SHALL never be blanked.
REQ-029 A non-BCD digit SHALL count as nonzero for blanking purposes.
REQ-030 A blanked slot SHALL drive dig_en = 000 and seg = 00.
REQ-031 err SHALL stay 1 until reset; later valid loads SHALL NOT clear it.

Reset
REQ-032 While rst == 1 at a clock edge: cnt = 0, FSM = S_UNITS, snapshot = 000, pending = 0.
REQ-033 While rst == 1 at a clock edge: seg = 00, dig_en = 000, frame_done = 0, err = 0.
REQ-034 rst SHALL take priority over upd and over the load edge in the same cycle.
REQ-035 After reset is released, the first snapshot load SHALL occur at the first frame end.
REQ-036 Reset asserted mid-slot SHALL restart the scan at units, cnt = 0, with no frame_done pulse.

Verification (SCAN_DIV=4, GUARD=1)
REQ-037 Reset release, no upd: every slot shows dig_en 000 except units slot cycles 2..4, which show dig_en 001, seg 7E.
REQ-038 num=3,0,5 with one upd pulse: after the next frame end, the units slot shows 001/5B, the tens slot 010/7E, and the hundreds slot 100/79.
REQ-039 num=0,0,7: hundreds and tens slots show 000/00; the units slot shows 001/70; frame_done pulses once every 12 cycles.
REQ-040 num2 = 4'hC loaded: the tens slot shows 010/01 and err rises one cycle after the load edge; a subsequent valid load leaves err at 1.
REQ-041 upd pulses in S_UNITS and in S_TENS with changing inputs: exactly one load occurs, with the values present on the frame-end edge; the displayed value does not change before frame_done.
REQ-042 rst asserted during the S_TENS slot: the next cycle shows seg 00, dig_en 000, err 0, and the scan restarts at S_UNITS with snapshot 000.
